// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state, per-stage control bundle and
// a saturating-increment helper used by the performance counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_freeze;
    logic exe_mem_freeze;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '0;

  // Increment q unless it already holds the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] q, input logic inc,
                                          input int unsigned w);
    logic [32:0] max_val;
    max_val = (33'd1 << w) - 33'd1;
    if (inc && (q != max_val[31:0])) begin
      return q + 32'd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= W'(sat_inc(32'(q), inc, W));
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall priority owner: memory stall > branch flush > hazard stall, with a
// memory-wait timeout watchdog. Performance counters exist only under STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned WAIT_W      = $clog2(MEM_TIMEOUT + 1),
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_freeze,
  output logic             exe_mem_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] haz_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e      state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  ctrl_t       ctrl;
  logic        mem_stall;
  logic        stall_active;
  logic        flush_eff;
  logic        haz_eff;

  assign mem_stall = mem_req && !sram_ready;

  always_comb begin
    ctrl         = CtrlNop;
    stall_active = 1'b0;
    flush_eff    = 1'b0;
    haz_eff      = 1'b0;
    if (!rst) begin
      stall_active = (state_q == StError) || mem_stall;
      flush_eff    = !stall_active && branch_taken;
      haz_eff      = !stall_active && !branch_taken && hazard_detected;
      ctrl.pc_freeze      = stall_active || haz_eff;
      ctrl.if_id_freeze   = stall_active || haz_eff;
      ctrl.if_id_flush    = flush_eff;
      ctrl.id_ex_bubble   = flush_eff || haz_eff;
      ctrl.id_ex_freeze   = stall_active;
      ctrl.exe_mem_freeze = stall_active;
      ctrl.mem_wb_bubble  = stall_active;
    end
  end

  assign pc_freeze      = ctrl.pc_freeze;
  assign if_id_freeze   = ctrl.if_id_freeze;
  assign if_id_flush    = ctrl.if_id_flush;
  assign id_ex_bubble   = ctrl.id_ex_bubble;
  assign id_ex_freeze   = ctrl.id_ex_freeze;
  assign exe_mem_freeze = ctrl.exe_mem_freeze;
  assign mem_wb_bubble  = ctrl.mem_wb_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_stall) begin
            state_q    <= StMemWait;
            wait_cnt_q <= WAIT_W'(1);
          end
        end
        StMemWait: begin
          // mem_req dropping counts as completion, same as sram_ready.
          if (mem_stall) begin
            if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
              state_q     <= StError;
              mem_timeout <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end
        end
        StError: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_haz_cnt (
    .clk (clk),
    .rst (rst),
    .inc (haz_eff),
    .q   (haz_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_active),
    .q   (mem_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_eff),
    .q   (flush_cnt)
  );
`else
  assign haz_stall_cnt = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Responder to the hazard detection unit and the SRAM memory stage in the 5-stage ARM pipeline. Consumes hazard_detected, branch_taken and the memory-stage ready handshake. Drives per-stage freeze, bubble and flush controls for the PC and the IF/ID, ID/EX, EXE/MEM and MEM/WB registers. Holds a memory-wait FSM with a timeout watchdog; it is the single owner of pipeline stall priority.

Parameters:
MEM_TIMEOUT, 64, max consecutive memory-wait cycles before the error state (must be >=2).
WAIT_W, $clog2(MEM_TIMEOUT+1), width of the wait counter.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
hazard_detected  input  1  RAW hazard from the hazard detection unit (ID stage).
branch_taken  input  1  taken branch resolved in EXE.
mem_req  input  1  MEM stage holds a load or store (mem_r_en | mem_w_en).
sram_ready  input  1  SRAM controller completes the current access this cycle.
pc_freeze  output  1  PC holds its value.
if_id_freeze  output  1  IF/ID register holds.
if_id_flush  output  1  IF/ID register loads a NOP.
id_ex_bubble  output  1  ID/EX register loads a NOP (control bits cleared).
id_ex_freeze  output  1  ID/EX register holds.
exe_mem_freeze  output  1  EXE/MEM register holds.
mem_wb_bubble  output  1  MEM/WB register loads a NOP.
mem_timeout  output  1  sticky error: memory wait exceeded MEM_TIMEOUT.
haz_stall_cnt  output  CNT_W  cycles stalled on hazard.
mem_stall_cnt  output  CNT_W  cycles stalled on memory.
flush_cnt  output  CNT_W  branch flushes.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset: state=RUN, wait_cnt=0, mem_timeout=0, counters=0. While rst=1 all control outputs are 0.
- Control outputs are combinational from state and inputs. State, wait_cnt, mem_timeout and counters are registered.
- Priority per cycle: memory stall > branch flush > hazard stall.
- Memory stall condition: mem_req=1 and sram_ready=0.
  - Outputs: pc_freeze, if_id_freeze, id_ex_freeze and exe_mem_freeze = 1; mem_wb_bubble=1; flush/bubble upstream = 0.
- RUN:
  - On memory stall, go to MEM_WAIT with wait_cnt=1.
  - Otherwise, if branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_freeze=0. hazard_detected is ignored.
  - Otherwise, if hazard_detected=1: pc_freeze=1, if_id_freeze=1, id_ex_bubble=1. EXE onward advances.
- MEM_WAIT:
  - While sram_ready=0, the memory-stall outputs are held and wait_cnt increments.
  - When sram_ready=1, the release cycle applies RUN rules for branch and hazard, and the next state is RUN with wait_cnt=0.
  - hazard_detected and branch_taken are ignored while frozen. Frozen stages re-present them on release.
  - If wait_cnt==MEM_TIMEOUT and sram_ready=0, go to ERROR.
- ERROR: mem_timeout=1 sticky; memory-stall outputs held permanently. Only rst exits.
- mem_req dropping to 0 in MEM_WAIT is treated as completion, same as sram_ready=1.
- rst asserted mid-wait returns to RUN on the next edge and clears mem_timeout.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: each counter saturates at 2^CNT_W-1.
  - haz_stall_cnt increments on each cycle with an effective hazard stall.
  - mem_stall_cnt increments on each cycle with memory-stall outputs active (including ERROR).
  - flush_cnt increments on each effective branch flush.
- Undefined: the three counter ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- pipe_ctrl_pkg holds the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2), a NOP-control constant and a counter-increment helper.
- Sub-module sat_counter (params W; ports clk, rst, inc, q) is instantiated three times under STALL_PERF_CNT_EN.

Test Plan:
- Hazard only: hazard_detected=1 for 2 cycles, no branch or mem -> pc_freeze=if_id_freeze=id_ex_bubble=1 for exactly 2 cycles; haz_stall_cnt=2.
- Branch beats hazard: branch_taken=1 and hazard_detected=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_freeze=0; flush_cnt=1, haz_stall_cnt=0.
- Memory wait: mem_req=1, sram_ready low 5 cycles then high -> all freezes plus mem_wb_bubble for 5 cycles; release cycle has all freezes 0; state back to RUN; mem_stall_cnt=5.
- Release with pending hazard: as above, with hazard_detected=1 throughout -> no hazard stall during the wait; on the release cycle pc_freeze=if_id_freeze=id_ex_bubble=1 and exe_mem_freeze=0.
- Timeout: MEM_TIMEOUT=4, sram_ready never asserted -> mem_timeout=1 after the 5th stall cycle and freezes held; rst for 1 cycle clears mem_timeout and all outputs.
- Saturation: CNT_W=4, hazard held 20 cycles -> haz_stall_cnt stops at 15.
